// File: rtl/memory_access_pkg.sv
// Shared types for the memory-access pipeline stage.
// Opcodes, funct3 encodings, FSM states and access-size decode.
package memory_access_pkg;

  localparam int REGISTER_WIDTH = 32;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQUEST,
    MEM_WAIT_DATA
  } mem_state_t;

  typedef enum logic [1:0] {
    SIZE_B,
    SIZE_H,
    SIZE_W
  } mem_size_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_t;

  // Unknown funct3 encodings fall back to a full-word access.
  function automatic mem_size_t access_size(
    input logic       is_store,
    input logic [2:0] funct3
  );
    mem_size_t s;
    s = SIZE_W;
    if (is_store) begin
      case (funct3)
        SB:      s = SIZE_B;
        SH:      s = SIZE_H;
        default: s = SIZE_W;
      endcase
    end else begin
      case (funct3)
        LB, LBU: s = SIZE_B;
        LH, LHU: s = SIZE_H;
        default: s = SIZE_W;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/memory_access_load_data_aligner.sv
// Load lane extraction and sign/zero extension.
// Purely combinational; funct3[2] selects unsigned loads.
module load_data_aligner
  import memory_access_pkg::*;
(
  input  logic [REGISTER_WIDTH-1:0] rdata,
  input  logic [2:0]                funct3,
  input  logic [1:0]                off,
  output logic [REGISTER_WIDTH-1:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed lane and extend it to register width.
  always_comb begin
    lane_b = rdata[{off, 3'b000} +: 8];
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];
    result = rdata;
    case (access_size(1'b0, funct3))
      SIZE_B: result = funct3[2]
                ? {{(REGISTER_WIDTH-8){1'b0}}, lane_b}
                : {{(REGISTER_WIDTH-8){lane_b[7]}}, lane_b};
      SIZE_H: result = funct3[2]
                ? {{(REGISTER_WIDTH-16){1'b0}}, lane_h}
                : {{(REGISTER_WIDTH-16){lane_h[15]}}, lane_h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access stage: RV32 loads/stores over req/gnt/rvalid.
// Optional MEMORY_ACCESS_MISALIGN_TRAP_EN adds a misaligned output.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  instruction_t              decoded_instruction,
  input  logic [REGISTER_WIDTH-1:0] alu_result,
  input  logic [REGISTER_WIDTH-1:0] rs2_value,
  output logic                      stall,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [3:0]                dmem_be,
  output logic [REGISTER_WIDTH-1:0] dmem_addr,
  output logic [REGISTER_WIDTH-1:0] dmem_wdata,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [REGISTER_WIDTH-1:0] dmem_rdata,
  output logic                      wb_valid,
  output instruction_t              wb_instruction,
  output logic [REGISTER_WIDTH-1:0] wb_data,
  output logic                      bus_error
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
  ,
  output logic                      misaligned
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  mem_state_t                state;
  logic [CNT_W-1:0]          cnt;
  instruction_t              instr_q;
  logic [1:0]                off_q;
  logic [REGISTER_WIDTH-1:0] load_data;

  logic                      is_load;
  logic                      is_store;
  logic                      is_mem;
  logic [1:0]                off;
  mem_size_t                 size;
  logic                      mis;
  logic                      go;
  logic [3:0]                be_n;
  logic [REGISTER_WIDTH-1:0] wdata_n;

  // Decode the incoming op and position store lanes.
  always_comb begin
    is_load  = decoded_instruction.opcode == OPCODE_LOAD;
    is_store = decoded_instruction.opcode == OPCODE_STORE;
    is_mem   = is_load | is_store;
    off      = alu_result[1:0];
    size     = access_size(is_store, decoded_instruction.funct3);
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    mis = ((size == SIZE_H) & off[0]) |
          ((size == SIZE_W) & (off != 2'b00));
`else
    mis = 1'b0;
`endif
    go = valid_in & is_mem & ~mis;
    case (size)
      SIZE_B: begin
        be_n    = 4'b0001 << off;
        wdata_n = {4{rs2_value[7:0]}};
      end
      SIZE_H: begin
        be_n    = 4'b0011 << {off[1], 1'b0};
        wdata_n = {2{rs2_value[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = rs2_value;
      end
    endcase
  end

  // Upstream is held while an access is in flight or being accepted.
  assign stall = (state != MEM_IDLE) | go;

  load_data_aligner u_aligner (
    .rdata  (dmem_rdata),
    .funct3 (instr_q.funct3),
    .off    (off_q),
    .result (load_data)
  );

  // Stage FSM with registered bus and writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= MEM_IDLE;
      cnt            <= '0;
      instr_q        <= '0;
      off_q          <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_be        <= '0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      wb_valid       <= 1'b0;
      wb_instruction <= '0;
      wb_data        <= '0;
      bus_error      <= 1'b0;
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
      misaligned     <= 1'b0;
`endif
    end else begin
      wb_valid  <= 1'b0;
      bus_error <= 1'b0;
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
      unique case (state)
        MEM_IDLE: begin
          cnt <= '0;
          if (valid_in && !is_mem) begin
            wb_valid       <= 1'b1;
            wb_data        <= alu_result;
            wb_instruction <= decoded_instruction;
          end
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
          else if (valid_in && mis) begin
            wb_valid       <= 1'b1;
            misaligned     <= 1'b1;
            wb_data        <= alu_result;
            wb_instruction <= decoded_instruction;
          end
`endif
          else if (go) begin
            instr_q    <= decoded_instruction;
            off_q      <= off;
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_be    <= be_n;
            dmem_addr  <= {alu_result[REGISTER_WIDTH-1:2], 2'b00};
            dmem_wdata <= is_store ? wdata_n : '0;
            state      <= MEM_REQUEST;
          end
        end
        MEM_REQUEST: begin
          cnt <= cnt + 1'b1;
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              wb_valid       <= 1'b1;
              wb_data        <= '0;
              wb_instruction <= instr_q;
              state          <= MEM_IDLE;
            end else begin
              state <= MEM_WAIT_DATA;
            end
          end else if (cnt >= LAST) begin
            dmem_req       <= 1'b0;
            wb_valid       <= 1'b1;
            bus_error      <= 1'b1;
            wb_data        <= '0;
            wb_instruction <= instr_q;
            state          <= MEM_IDLE;
          end
        end
        MEM_WAIT_DATA: begin
          cnt <= cnt + 1'b1;
          if (dmem_rvalid) begin
            wb_valid       <= 1'b1;
            wb_data        <= load_data;
            wb_instruction <= instr_q;
            state          <= MEM_IDLE;
          end else if (cnt >= LAST) begin
            wb_valid       <= 1'b1;
            bus_error      <= 1'b1;
            wb_data        <= '0;
            wb_instruction <= instr_q;
            state          <= MEM_IDLE;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule
